// File: rtl/iso_lane_deframer.sv
// Sink-side per-lane parser of the DisplayPort isochronous symbol stream.
// Recovers pixel bytes, secondary-packet bytes and VB-ID/Mvid/Maud attributes.
module iso_lane_deframer #(
    parameter logic [7:0] BS_CODE = 8'hBC,
    parameter logic [7:0] BE_CODE = 8'hFB,
    parameter logic [7:0] SR_CODE = 8'h1C,
    parameter logic [7:0] SS_CODE = 8'h5C,
    parameter logic [7:0] SE_CODE = 8'hFD,
    parameter logic [7:0] FS_CODE = 8'hFE,
    parameter logic [7:0] FE_CODE = 8'hF7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_symbols,
    input  logic       rx_control_sym_flag,
    input  logic       rx_vld,
    input  logic [1:0] td_lane_count,
    output logic [7:0] pix_data,
    output logic       pix_vld,
    output logic [7:0] sec_data,
    output logic       sec_vld,
    output logic       sec_end,
    output logic [7:0] vbid,
    output logic [7:0] mvid,
    output logic [7:0] maud,
    output logic       attr_upd,
    output logic       attr_mismatch,
    output logic       sr_det,
    output logic       sym_err,
    output logic [1:0] deframer_state
);

    typedef enum logic [2:0] {
        ST_HUNT, ST_BLANK, ST_VBSEQ, ST_SEC, ST_ACTIVE, ST_FILL
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] pos_q, pos_d;            // byte position within the triplet
    logic [1:0] rep_q, rep_d;            // triplet copy index
    logic [1:0] rep_last_q, rep_last_d;  // index of the final copy, latched at BS/SR
    logic [7:0] sh_vbid_q, sh_vbid_d, sh_mvid_q, sh_mvid_d, sh_maud_q, sh_maud_d;
    logic [7:0] vbid_q, vbid_d, mvid_q, mvid_d, maud_q, maud_d;
    logic [7:0] pix_data_q, pix_data_d, sec_data_q, sec_data_d;
    logic       pix_vld_q, pix_vld_d, sec_vld_q, sec_vld_d, sec_end_q, sec_end_d;
    logic       attr_upd_q, attr_upd_d, attr_mismatch_q, attr_mismatch_d;
    logic       sr_det_q, sr_det_d, sym_err_q, sym_err_d;
    logic [1:0] dstate_q, dstate_d;

    logic       is_k, is_bs;
    logic [7:0] shadow_byte;

    always_comb begin
        state_d         = state_q;
        pos_d           = pos_q;
        rep_d           = rep_q;
        rep_last_d      = rep_last_q;
        sh_vbid_d       = sh_vbid_q;
        sh_mvid_d       = sh_mvid_q;
        sh_maud_d       = sh_maud_q;
        vbid_d          = vbid_q;
        mvid_d          = mvid_q;
        maud_d          = maud_q;
        pix_data_d      = pix_data_q;
        sec_data_d      = sec_data_q;
        pix_vld_d       = 1'b0;
        sec_vld_d       = 1'b0;
        sec_end_d       = 1'b0;
        attr_upd_d      = 1'b0;
        attr_mismatch_d = 1'b0;
        sr_det_d        = 1'b0;
        sym_err_d       = 1'b0;
        is_k            = rx_control_sym_flag;
        is_bs           = rx_control_sym_flag &&
                          (rx_symbols == BS_CODE || rx_symbols == SR_CODE);
        case (pos_q)
            2'd0:    shadow_byte = sh_vbid_q;
            2'd1:    shadow_byte = sh_mvid_q;
            default: shadow_byte = sh_maud_q;
        endcase

        if (rx_vld) begin
            if (is_bs) begin
                sym_err_d = (state_q == ST_SEC) || (state_q == ST_FILL);
                sr_det_d  = (rx_symbols == SR_CODE);
                state_d   = ST_VBSEQ;
                pos_d     = 2'd0;
                rep_d     = 2'd0;
                case (td_lane_count)
                    2'b00:   rep_last_d = 2'd3;
                    2'b01:   rep_last_d = 2'd1;
                    default: rep_last_d = 2'd0;
                endcase
            end else begin
                case (state_q)
                    ST_VBSEQ: begin
                        if (is_k) begin
                            sym_err_d = 1'b1;
                            state_d   = ST_HUNT;
                        end else begin
                            if (rep_q == 2'd0) begin
                                case (pos_q)
                                    2'd0:    sh_vbid_d = rx_symbols;
                                    2'd1:    sh_mvid_d = rx_symbols;
                                    default: sh_maud_d = rx_symbols;
                                endcase
                            end else if (rx_symbols != shadow_byte) begin
                                attr_mismatch_d = 1'b1;
                            end
                            if (pos_q == 2'd2 && rep_q == rep_last_q) begin
                                // Single-copy case: Maud is still on the wire, not in the shadow
                                vbid_d     = sh_vbid_q;
                                mvid_d     = sh_mvid_q;
                                maud_d     = (rep_q == 2'd0) ? rx_symbols : sh_maud_q;
                                attr_upd_d = 1'b1;
                                state_d    = ST_BLANK;
                            end else if (pos_q == 2'd2) begin
                                pos_d = 2'd0;
                                rep_d = rep_q + 2'd1;
                            end else begin
                                pos_d = pos_q + 2'd1;
                            end
                        end
                    end
                    ST_BLANK: begin
                        if (is_k) begin
                            if (rx_symbols == SS_CODE)      state_d = ST_SEC;
                            else if (rx_symbols == BE_CODE) state_d = ST_ACTIVE;
                            else                            sym_err_d = 1'b1;
                        end
                    end
                    ST_SEC: begin
                        if (!is_k) begin
                            sec_data_d = rx_symbols;
                            sec_vld_d  = 1'b1;
                        end else if (rx_symbols == SE_CODE) begin
                            sec_end_d = 1'b1;
                            state_d   = ST_BLANK;
                        end else begin
                            sym_err_d = 1'b1;
                            state_d   = ST_HUNT;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!is_k) begin
                            pix_data_d = rx_symbols;
                            pix_vld_d  = 1'b1;
                        end else if (rx_symbols == FS_CODE) begin
                            state_d = ST_FILL;
                        end else begin
                            sym_err_d = 1'b1;
                        end
                    end
                    ST_FILL: begin
                        if (is_k) begin
                            if (rx_symbols == FE_CODE) begin
                                state_d = ST_ACTIVE;
                            end else begin
                                sym_err_d = 1'b1;
                                state_d   = ST_HUNT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        case (state_d)
            ST_HUNT:   dstate_d = 2'b00;
            ST_ACTIVE: dstate_d = 2'b10;
            ST_FILL:   dstate_d = 2'b11;
            default:   dstate_d = 2'b01;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_HUNT;
            pos_q           <= 2'd0;
            rep_q           <= 2'd0;
            rep_last_q      <= 2'd0;
            sh_vbid_q       <= 8'd0;
            sh_mvid_q       <= 8'd0;
            sh_maud_q       <= 8'd0;
            vbid_q          <= 8'd0;
            mvid_q          <= 8'd0;
            maud_q          <= 8'd0;
            pix_data_q      <= 8'd0;
            sec_data_q      <= 8'd0;
            pix_vld_q       <= 1'b0;
            sec_vld_q       <= 1'b0;
            sec_end_q       <= 1'b0;
            attr_upd_q      <= 1'b0;
            attr_mismatch_q <= 1'b0;
            sr_det_q        <= 1'b0;
            sym_err_q       <= 1'b0;
            dstate_q        <= 2'b00;
        end else begin
            state_q         <= state_d;
            pos_q           <= pos_d;
            rep_q           <= rep_d;
            rep_last_q      <= rep_last_d;
            sh_vbid_q       <= sh_vbid_d;
            sh_mvid_q       <= sh_mvid_d;
            sh_maud_q       <= sh_maud_d;
            vbid_q          <= vbid_d;
            mvid_q          <= mvid_d;
            maud_q          <= maud_d;
            pix_data_q      <= pix_data_d;
            sec_data_q      <= sec_data_d;
            pix_vld_q       <= pix_vld_d;
            sec_vld_q       <= sec_vld_d;
            sec_end_q       <= sec_end_d;
            attr_upd_q      <= attr_upd_d;
            attr_mismatch_q <= attr_mismatch_d;
            sr_det_q        <= sr_det_d;
            sym_err_q       <= sym_err_d;
            dstate_q        <= dstate_d;
        end
    end

    assign pix_data       = pix_data_q;
    assign pix_vld        = pix_vld_q;
    assign sec_data       = sec_data_q;
    assign sec_vld        = sec_vld_q;
    assign sec_end        = sec_end_q;
    assign vbid           = vbid_q;
    assign mvid           = mvid_q;
    assign maud           = maud_q;
    assign attr_upd       = attr_upd_q;
    assign attr_mismatch  = attr_mismatch_q;
    assign sr_det         = sr_det_q;
    assign sym_err        = sym_err_q;
    assign deframer_state = dstate_q;

endmodule

// File: doc/iso_lane_deframer.md
Name: iso_lane_deframer

Overview:
- Sink-side, per-lane parser of the DisplayPort isochronous symbol stream: the receive counterpart of the source ISO lane path (active mapping, blank mapping, idle pattern, SR insertion).
- Consumes one 8-bit symbol per valid cycle plus its control-symbol flag and tracks blanking, VB-ID/Mvid/Maud, secondary packets and active pixel data with fill.
- Emits the recovered pixel bytes, secondary-data bytes and stream attributes toward the sink stream unpacker.

Parameters:
- BS_CODE, 8'hBC, blanking start (K28.5).
- BE_CODE, 8'hFB, blanking end (K27.7).
- SR_CODE, 8'h1C, scrambler reset (K28.0), replaces BS.
- SS_CODE, 8'h5C, secondary start (K28.2).
- SE_CODE, 8'hFD, secondary end (K29.7).
- FS_CODE, 8'hFE, fill start (K30.7).
- FE_CODE, 8'hF7, fill end (K23.7).

Ports:
- clk in 1: symbol clock.
- rst_n in 1: asynchronous active-low reset.
- rx_symbols in 8: descrambled lane symbol.
- rx_control_sym_flag in 1: 1 = rx_symbols is a K-code.
- rx_vld in 1: symbol qualifier; nothing advances when 0.
- td_lane_count in 2: 00 = 1 lane, 01 = 2 lanes, 11 = 4 lanes (10 is treated as 4).
- pix_data out 8: active pixel byte.
- pix_vld out 1: pix_data qualifier.
- sec_data out 8: secondary-packet byte.
- sec_vld out 1: sec_data qualifier.
- sec_end out 1: one-cycle pulse on SE.
- vbid out 8: last accepted VB-ID.
- mvid out 8: last accepted Mvid[7:0].
- maud out 8: last accepted Maud[7:0].
- attr_upd out 1: one-cycle pulse when vbid/mvid/maud update.
- attr_mismatch out 1: one-cycle pulse when a repeat copy differs from the first copy.
- sr_det out 1: one-cycle pulse on SR.
- sym_err out 1: one-cycle pulse on an illegal symbol.
- deframer_state out 2: 00 = HUNT, 01 = BLANK, 10 = ACTIVE, 11 = FILL.

Behaviour:
- Registered outputs:
  - All outputs are registered.
  - Latency is 1 clk from the accepted input symbol to the output.
  - When rx_vld = 0, all pulses and valids are 0 and state and counters hold.
- Reset values:
  - Every output is 0; deframer_state = HUNT.
  - The VB-ID sequence counter and repeat counter are 0.
- FSM states: HUNT, BLANK, VBSEQ (internal; reported as BLANK), SEC (internal; reported as BLANK), ACTIVE, FILL.
- BS or SR (K) received in any state:
  - Go to VBSEQ and load the byte counter = 0.
  - SR also pulses sr_det.
  - BS/SR received while in SEC or FILL additionally pulses sym_err.
- VBSEQ:
  - Expects the triplet VB-ID, Mvid, Maud as data symbols, repeated R times: R = 4 (1 lane), 2 (2 lanes), 1 (4 lanes). Total is 3*R bytes.
  - The first triplet is captured into shadow registers.
  - Each later copy is compared byte-wise with the shadow; any difference pulses attr_mismatch once, in the cycle of the differing byte.
  - After the final byte: vbid/mvid/maud load from the shadow, attr_upd pulses, and the state goes to BLANK.
  - A K symbol inside VBSEQ:
    - If BS/SR, restart VBSEQ.
    - Otherwise pulse sym_err and go to HUNT; attributes are not updated.
- BLANK:
  - Data symbols are dummy and discarded.
  - SS goes to SEC.
  - BE goes to ACTIVE.
  - Any other K except BS/SR pulses sym_err and stays in BLANK.
- SEC:
  - Each data symbol drives sec_data with sec_vld = 1.
  - SE pulses sec_end and returns to BLANK.
  - Any other K pulses sym_err and goes to HUNT.
- ACTIVE:
  - Each data symbol drives pix_data with pix_vld = 1.
  - FS goes to FILL.
  - BS/SR goes to VBSEQ.
  - Any other K pulses sym_err and stays in ACTIVE.
- FILL:
  - Data symbols are discarded.
  - FE returns to ACTIVE.
  - FS immediately followed by FE (zero-length fill) is legal.
  - Any other K except BS/SR pulses sym_err and goes to HUNT.
- HUNT:
  - All symbols are discarded until BS/SR. A data symbol in HUNT is not an error.
- td_lane_count is sampled on BS/SR entry to VBSEQ. A change mid-sequence has no effect until the next BS.
- Only one error pulse is generated per symbol. sym_err and attr_mismatch never assert in the same cycle.

Test Plan:
- Reset, then 1 lane: BS, then 12 data bytes (55,12,34 ×4), then BE, then 4 data bytes.
  - Response: attr_upd pulses once, 1 clk after the 12th byte.
  - vbid = 55, mvid = 12, maud = 34.
  - The 4 bytes appear on pix_vld; deframer_state = 10.
- 4 lanes: SR, then 3 bytes (01,AA,BB).
  - Response: sr_det pulses; attr_upd pulses after the 3rd byte; no mismatch.
- 2 lanes: BS, then 01,AA,BB,01,AB,BB.
  - Response: attr_mismatch pulses aligned to byte 5; attributes still update from the first copy.
- BLANK: SS, then 3 data bytes, then SE.
  - Response: 3 sec_vld bytes, then a sec_end pulse.
- ACTIVE: BE, then data, FS, 2 dummy bytes, FE, 1 data byte.
  - Response: pix_vld is 0 for the dummy bytes; deframer_state passes 10→11→10.
- Errors:
  - BE while in SEC pulses sym_err and returns to HUNT; subsequent data is dropped until BS.
  - rx_vld low for 5 cycles mid-VBSEQ: the counter holds and completion is still correct.
  - rst_n asserted mid-ACTIVE clears all outputs asynchronously.
